// File: rtl/if_fetch_if.sv
// Byte-read bus between the fetch stage (master) and the memory controller (slave).
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: PC plus direct-mapped word cache; hits issue 1 instr/cycle,
// misses gather four bytes over the memory bus while holding stallreq_if high.
module if_fetch #(
  parameter int          CACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_from_ex,
  input  logic [31:0] branch_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  if_fetch_if.master  mem_bus,
  output logic        stallreq_if,
  output logic        if_flag,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);
  localparam int DEPTH = 1 << CACHE_IDX_W;
  localparam int TAG_W = 30 - CACHE_IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] buf_q, buf_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        stallreq_q, stallreq_d;
  logic        if_flag_q, if_flag_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic             cache_we;

  logic [CACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   stop;
  logic                   ack;
  logic [31:0]            pc_seq;
  logic [31:0]            word;
  logic                   unused_stall;

  assign idx          = pc_q[CACHE_IDX_W+1:2];
  assign tag          = pc_q[31:CACHE_IDX_W+2];
  assign hit          = valid_q[idx] && (tag_mem[idx] == tag);
  assign stop         = stall[0];
  assign ack          = mem_bus.mem_ack && mem_req_q;
  assign pc_seq       = pred_taken ? pred_target : pc_q + 32'd4;
  assign word         = {mem_bus.mem_data, buf_q};
  assign unused_stall = ^stall[5:1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    stallreq_d = stallreq_q;
    if_flag_d  = if_flag_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    valid_d    = valid_q;
    cache_we   = 1'b0;

    if (branch_from_ex) begin
      // Redirect wins over stall; any partially assembled word is dropped.
      state_d    = IDLE;
      pc_d       = branch_target;
      byte_cnt_d = '0;
      mem_req_d  = 1'b0;
      stallreq_d = 1'b0;
      if_flag_d  = 1'b0;
      if_inst_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stop) begin
            if (hit) begin
              if_flag_d = 1'b1;
              if_pc_d   = pc_q;
              if_inst_d = data_mem[idx];
              pc_d      = pc_seq;
            end else begin
              state_d    = MISS;
              byte_cnt_d = '0;
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              stallreq_d = 1'b1;
              if_flag_d  = 1'b0;
            end
          end
        end
        MISS: begin
          if (ack) begin
            if (byte_cnt_q == 2'd3) begin
              cache_we     = 1'b1;
              valid_d[idx] = 1'b1;
              byte_cnt_d   = '0;
              mem_req_d    = 1'b0;
              stallreq_d   = 1'b0;
              if_flag_d    = 1'b1;
              if_pc_d      = pc_q;
              if_inst_d    = word;
              if (stop) begin
                state_d = HOLD;
              end else begin
                state_d = IDLE;
                pc_d    = pc_seq;
              end
            end else begin
              case (byte_cnt_q)
                2'd0:    buf_d[7:0]   = mem_bus.mem_data;
                2'd1:    buf_d[15:8]  = mem_bus.mem_data;
                default: buf_d[23:16] = mem_bus.mem_data;
              endcase
              byte_cnt_d = byte_cnt_q + 2'd1;
              mem_addr_d = pc_q + {30'd0, byte_cnt_q + 2'd1};
            end
          end
        end
        HOLD: begin
          if (!stop) begin
            state_d = IDLE;
            pc_d    = pc_seq;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      stallreq_q <= 1'b0;
      if_flag_q  <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      stallreq_q <= stallreq_d;
      if_flag_q  <= if_flag_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data need no reset: valid_q gates every hit.
  always_ff @(posedge clk) begin
    if (cache_we && !rst) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= word;
    end
  end

  assign mem_bus.mem_req  = mem_req_q;
  assign mem_bus.mem_addr = mem_addr_q;
  assign stallreq_if      = stallreq_q;
  assign if_flag          = if_flag_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic against a transaction-level model.
module tb_if_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] bt;
  logic        pt;
  logic [31:0] ptgt;
  logic        stallreq_if;
  logic        if_flag;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch_if mem_bus();

  if_fetch #(.CACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_from_ex (br),
    .branch_target  (bt),
    .pred_taken     (pt),
    .pred_target    (ptgt),
    .mem_bus        (mem_bus),
    .stallreq_if    (stallreq_if),
    .if_flag        (if_flag),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Backing byte memory and the model's view of the cache: slot -> aligned address / word.
  logic [7:0]  mem [4096];
  logic [31:0] c_addr [int];
  logic [31:0] c_word [int];

  logic [31:0] m_pc, m_addr, m_ifpc, m_inst;
  bit          m_req, m_stallreq, m_flag, m_fetching, m_holding;
  logic [7:0]  m_bytes [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd64);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[12'(a + 3)], mem[12'(a + 2)], mem[12'(a + 1)], mem[12'(a)]};
  endfunction

  task automatic model_step(input bit ack, input logic [7:0] d);
    logic [31:0] nxt;
    logic [31:0] w;
    int          s;
    nxt = pt ? ptgt : m_pc + 32'd4;
    if (rst) begin
      m_pc = 0; m_addr = 0; m_ifpc = 0; m_inst = 0;
      m_req = 0; m_stallreq = 0; m_flag = 0; m_fetching = 0; m_holding = 0;
      m_bytes.delete();
      c_addr.delete();
      c_word.delete();
    end else if (br) begin
      m_pc = bt; m_flag = 0; m_inst = 0; m_req = 0; m_stallreq = 0;
      m_fetching = 0; m_holding = 0;
      m_bytes.delete();
    end else if (m_holding) begin
      if (!stall[0]) begin
        m_pc = nxt;
        m_holding = 0;
      end
    end else if (m_fetching) begin
      if (ack) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          s = slot_of(m_pc);
          c_addr[s] = m_pc & ~32'h3;
          c_word[s] = w;
          m_fetching = 0; m_req = 0; m_stallreq = 0;
          m_flag = 1; m_ifpc = m_pc; m_inst = w;
          m_bytes.delete();
          if (stall[0]) m_holding = 1;
          else m_pc = nxt;
        end else begin
          m_addr = m_pc + 32'(m_bytes.size());
        end
      end
    end else if (!stall[0]) begin
      s = slot_of(m_pc);
      if (c_addr.exists(s) && c_addr[s] == (m_pc & ~32'h3)) begin
        m_flag = 1; m_ifpc = m_pc; m_inst = c_word[s]; m_pc = nxt;
      end else begin
        m_fetching = 1; m_req = 1; m_addr = m_pc; m_stallreq = 1; m_flag = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk_eq("mem_req", 32'(mem_bus.mem_req), 32'(m_req));
    if (m_req) chk_eq("mem_addr", mem_bus.mem_addr, m_addr);
    chk_eq("stallreq_if", 32'(stallreq_if), 32'(m_stallreq));
    chk_eq("if_flag", 32'(if_flag), 32'(m_flag));
    chk_eq("if_pc", if_pc, m_ifpc);
    chk_eq("if_inst", if_inst, m_inst);
  endtask

  // One clock: present inputs, advance the model, then compare on the falling edge.
  task automatic tick(input bit ack);
    logic [7:0] d;
    d = m_req ? mem[m_addr[11:0]] : 8'($urandom);
    mem_bus.mem_ack  = ack;
    mem_bus.mem_data = d;
    model_step(ack, d);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic branch_to(input logic [31:0] a);
    br = 1'b1; bt = a;
    tick(1'b0);
    br = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(99));
    if (r < 2) return 32'hFFFF_FFFC;
    if (r < 4) return $urandom & 32'h1FF;
    return 32'($urandom_range(127)) * 32'd4;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
    rst = 1'b1; stall = '0; br = 1'b0; bt = '0; pt = 1'b0; ptgt = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_data = '0;
    @(negedge clk);

    // Reset, with a stray ack that must be ignored.
    tick(1'b1);
    tick(1'b0);
    chk_eq("rst_flag", 32'(if_flag), 0);
    chk_eq("rst_pc", if_pc, 0);
    chk_eq("rst_inst", if_inst, 0);
    chk_eq("rst_req", 32'(mem_bus.mem_req), 0);
    chk_eq("rst_addr", mem_bus.mem_addr, 0);
    chk_eq("rst_stallreq", 32'(stallreq_if), 0);
    rst = 1'b0;

    // Cold miss at pc 0: four byte reads.
    tick(1'b0);
    chk_eq("t1_req", 32'(mem_bus.mem_req), 1);
    chk_eq("t1_stallreq", 32'(stallreq_if), 1);
    for (int i = 0; i < 4; i++) begin
      chk_eq("t1_byte_addr", mem_bus.mem_addr, 32'(i));
      tick(1'b1);
      if (i < 3) chk_eq("t1_stallreq_busy", 32'(stallreq_if), 1);
    end
    chk_eq("t1_flag", 32'(if_flag), 1);
    chk_eq("t1_pc", if_pc, 0);
    chk_eq("t1_inst", if_inst, 32'h0010_0093);
    chk_eq("t1_stallreq_done", 32'(stallreq_if), 0);
    tick(1'b0);
    chk_eq("t1_next_addr", mem_bus.mem_addr, 32'h4);

    // Loop back to 0: cache hit, no memory traffic.
    branch_to(32'h0);
    tick(1'b0);
    chk_eq("t2_flag", 32'(if_flag), 1);
    chk_eq("t2_pc", if_pc, 0);
    chk_eq("t2_inst", if_inst, 32'h0010_0093);
    chk_eq("t2_req", 32'(mem_bus.mem_req), 0);
    tick(1'b0);

    // Redirect after two acks; the same-cycle ack is discarded.
    tick(1'b1);
    tick(1'b1);
    br = 1'b1; bt = 32'h100;
    tick(1'b1);
    br = 1'b0;
    chk_eq("t3_req", 32'(mem_bus.mem_req), 0);
    chk_eq("t3_flag", 32'(if_flag), 0);
    chk_eq("t3_inst", if_inst, 0);
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_eq("t3_byte_addr", mem_bus.mem_addr, 32'h100 + 32'(i));
      tick(1'b1);
    end
    chk_eq("t3_pc", if_pc, 32'h100);
    chk_eq("t3_inst", if_inst, mem_word(32'h100));
    branch_to(32'h4);
    tick(1'b0);
    chk_eq("t3_partial_not_cached", 32'(mem_bus.mem_req), 1);

    // Predicted-taken hit at pc 8.
    branch_to(32'h8);
    tick(1'b0);
    repeat (4) tick(1'b1);
    branch_to(32'h8);
    pt = 1'b1; ptgt = 32'h40;
    tick(1'b0);
    pt = 1'b0;
    chk_eq("t5_hit_pc", if_pc, 32'h8);
    chk_eq("t5_hit_req", 32'(mem_bus.mem_req), 0);
    tick(1'b0);
    chk_eq("t5_target_addr", mem_bus.mem_addr, 32'h40);
    repeat (4) tick(1'b1);
    chk_eq("t5_target_pc", if_pc, 32'h40);

    // Stall arriving with the fourth ack.
    branch_to(32'h200);
    tick(1'b0);
    repeat (3) tick(1'b1);
    stall = 6'b000001;
    tick(1'b1);
    chk_eq("t4_flag", 32'(if_flag), 1);
    chk_eq("t4_pc", if_pc, 32'h200);
    chk_eq("t4_inst", if_inst, mem_word(32'h200));
    repeat (3) begin
      tick($urandom_range(1) == 1);
      chk_eq("t4_hold_flag", 32'(if_flag), 1);
      chk_eq("t4_hold_inst", if_inst, mem_word(32'h200));
      chk_eq("t4_hold_req", 32'(mem_bus.mem_req), 0);
    end
    stall = '0;
    tick(1'b0);
    tick(1'b0);
    chk_eq("t4_advance_once", mem_bus.mem_addr, 32'h204);

    // pc wrap-around at the top of the address space.
    branch_to(32'hFFFF_FFFC);
    tick(1'b0);
    repeat (4) tick(1'b1);
    chk_eq("t7_pc", if_pc, 32'hFFFF_FFFC);
    tick(1'b0);
    chk_eq("t7_wrap_addr", mem_bus.mem_addr, 32'h0);

    // Reset during a miss after one ack.
    branch_to(32'h300);
    tick(1'b0);
    tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    chk_eq("t6_flag", 32'(if_flag), 0);
    chk_eq("t6_pc", if_pc, 0);
    chk_eq("t6_inst", if_inst, 0);
    chk_eq("t6_req", 32'(mem_bus.mem_req), 0);
    rst = 1'b0;
    tick(1'b1);
    chk_eq("t6_cold_miss", 32'(mem_bus.mem_req), 1);
    repeat (4) tick(1'b1);
    chk_eq("t6_inst_after", if_inst, 32'h0010_0093);
    branch_to(32'h300);
    tick(1'b0);
    chk_eq("t6_entry_absent", 32'(mem_bus.mem_req), 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(199) == 0);
      br       = ($urandom_range(29) == 0);
      bt       = rand_addr();
      stall    = 6'($urandom);
      stall[0] = ($urandom_range(4) == 0);
      pt       = ($urandom_range(9) == 0);
      ptgt     = rand_addr();
      tick($urandom_range(99) < 60);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RISC-V core. Sits between the PC/branch logic and the IF/ID pipeline register.
- Owns the PC and a direct-mapped, word-granular instruction cache.
- On a cache miss it assembles a 32-bit instruction from four byte reads through the memory controller.
- Presents {if_flag, if_pc, if_inst} to IF/ID and requests a pipeline stall while fetching.

Parameters:
- CACHE_IDX_W, 6, index bits; 2^CACHE_IDX_W one-word entries; index = pc[CACHE_IDX_W+1:2], tag = pc[31:CACHE_IDX_W+2]
- RESET_PC, 32'h0, PC value after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`Enable)
- stall  in  6  stall vector from stallctrl; stall[0] == `Stop freezes this stage
- branch_from_ex  in  1  EX resolved a misprediction; redirect
- branch_target  in  32  redirect PC
- pred_taken  in  1  predictor says taken for current if_pc
- pred_target  in  32  predicted target
- mem_req  out  1  byte read request to memctrl
- mem_addr  out  32  byte address of request
- mem_ack  in  1  memctrl returns requested byte this cycle
- mem_data  in  8  returned byte
- stallreq_if  out  1  to stallctrl; high while a miss is in progress
- if_flag  out  1  if_pc/if_inst valid
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  instruction word

Behaviour:
- Reset (rst high at posedge):
  - pc = RESET_PC, state = IDLE, byte_cnt = 0
  - all cache valid bits cleared
  - mem_req = 0, mem_addr = 0, stallreq_if = 0, if_flag = 0, if_pc = 0, if_inst = 0
  - reset mid-miss abandons the fetch; a later mem_ack is ignored
- States: IDLE (lookup), MISS (byte fetch), HOLD (output stalled).
- IDLE:
  - Combinational lookup of pc.
  - Hit: next edge registers if_flag = 1, if_pc = pc, if_inst = cached word; pc <= pred_taken ? pred_target : pc+4. Throughput 1 instr/cycle.
  - Miss: next edge enters MISS with byte_cnt = 0, mem_req = 1, mem_addr = pc, stallreq_if = 1, if_flag = 0.
- MISS:
  - mem_req held high. On each mem_ack, mem_data is stored into buffer byte byte_cnt (little-endian; byte 0 = bits 7:0), byte_cnt increments and mem_addr = pc + byte_cnt.
  - On the 4th ack:
    - write the cache entry (tag, valid, word) and drop mem_req and stallreq_if
    - register if_flag = 1, if_pc = pc, if_inst = assembled word
    - advance pc as on a hit and return to IDLE
  - If stall[0] == `Stop on that edge, go to HOLD instead and do not advance pc.
- HOLD / stall[0] == `Stop:
  - pc and outputs are frozen, with if_flag kept at its current value.
  - In IDLE, no lookup result is consumed.
  - In MISS, byte collection continues, but completion goes to HOLD.
  - On release: HOLD advances pc and returns to IDLE, with outputs updated on the next lookup.
- branch_from_ex:
  - Highest priority after rst, regardless of stall.
  - Edge effects: pc = branch_target, if_flag = 0, if_inst = 0, state = IDLE, byte_cnt = 0, mem_req = 0, stallreq_if = 0.
  - An ack in the same cycle is discarded and the partial word is not written to the cache.
- Arithmetic: pc+4 and pc+byte_cnt are 32-bit wrap-around; 32'hFFFFFFFC + 4 = 0.
- Misaligned branch_target (bits 1:0 ≠ 0): fetched as-is, byte reads from the exact address; cache index/tag ignore pc[1:0]. This is only legal for aligned code.
- mem_ack while mem_req == 0 is ignored.

Test Plan:
- Reset, pc=0, memory bytes 0..3 = 93 00 10 00 → 4 acks, stallreq_if high throughout, then if_flag=1, if_pc=0, if_inst=32'h00100093; pc=4.
- Loop back to pc=0 after warm-up → hit: if_flag=1, if_inst=32'h00100093 the cycle after lookup, no mem_req.
- branch_from_ex=1, target=32'h100 after 2 of 4 acks → mem_req=0, if_flag=0 next cycle; a re-fetch of 0x100 issues 4 fresh requests; the old partial word is never visible.
- stall[0]=Stop asserted on the 4th ack → if_flag=1 with the word held while stalled; pc advances exactly once after release.
- pred_taken=1, pred_target=32'h40 on a hit at pc=8 → next if_pc=32'h40.
- rst asserted mid-miss after 1 ack → all outputs 0, a cache entry for that pc is absent on the next access (miss), and a stray mem_ack is ignored.
